// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus-side state encoding, default device address
// and bit-counter width, used by both the target responder and the master FSM.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_t;

  localparam logic [6:0] I2C_DEV_ADDR_DEF = 7'h68;
  localparam int         I2C_BIT_CNT_W    = 3;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus history flop for one open-drain I2C line.
// Flops reset to 1 so an idle (pulled-up) bus produces no spurious edges.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_hist;
  assign o_fall  = ~r_sync & r_hist;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target with address match, register pointer, burst write and
// auto-incrementing burst read over a small register file.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR_DEF,
  parameter int         REG_DEPTH   = 16,
  parameter int         WHOAMI_ADDR = 15,
  parameter logic [7:0] WHOAMI_VAL  = 8'h68
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_scl_in,
  input  logic                         i_sda_in,
  output logic                         o_sda_oe,
  output logic                         o_wr_strobe,
  output logic [$clog2(REG_DEPTH)-1:0] o_wr_addr,
  output logic [7:0]                   o_wr_data,
  output logic                         o_busy
);

  localparam int             AW         = $clog2(REG_DEPTH);
  localparam logic [AW-1:0]  WHOAMI_IDX = AW'(WHOAMI_ADDR);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;

  i2c_line_sync u_scl_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_line  (i_scl_in),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_line  (i_sda_in),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  logic w_start, w_stop;
  assign w_start = w_sda_fall & w_scl_lvl;
  assign w_stop  = w_sda_rise & w_scl_lvl;

  i2c_state_t               r_state, w_state_nxt;
  logic [I2C_BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]               r_shift, w_shift_nxt;
  logic [AW-1:0]            r_ptr, w_ptr_nxt;
  logic                     r_sda_oe, w_sda_oe_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_slot, w_slot_nxt;
  logic                     r_rw, w_rw_nxt;
  logic                     r_mack, w_mack_nxt;
  logic                     r_wr_strobe, w_wr_strobe_nxt;
  logic [AW-1:0]            r_wr_addr, w_wr_addr_nxt;
  logic [7:0]               r_wr_data, w_wr_data_nxt;
  logic                     w_reg_we;

  logic [7:0] r_regs [REG_DEPTH];
  logic [7:0] w_byte;
  logic [7:0] w_rd_byte;
  logic       w_last_bit;

  assign w_byte     = {r_shift[6:0], w_sda_lvl};
  assign w_rd_byte  = (r_ptr == WHOAMI_IDX) ? WHOAMI_VAL : r_regs[r_ptr];
  assign w_last_bit = (r_bit_cnt == '1);

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_ptr_nxt       = r_ptr;
    w_sda_oe_nxt    = r_sda_oe;
    w_busy_nxt      = r_busy;
    w_slot_nxt      = r_slot;
    w_rw_nxt        = r_rw;
    w_mack_nxt      = r_mack;
    w_wr_strobe_nxt = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_reg_we        = 1'b0;

    if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_slot_nxt    = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = ST_ADDR;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
      w_slot_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            w_slot_nxt    = 1'b0;
            if (w_last_bit) begin
              if (r_state == ST_ADDR) begin
                if (w_byte[7:1] == DEV_ADDR) begin
                  w_state_nxt = ST_ADDR_ACK;
                  w_busy_nxt  = 1'b1;
                  w_rw_nxt    = w_byte[0];
                end else begin
                  w_state_nxt = ST_WAIT_STOP;
                  w_busy_nxt  = 1'b0;
                end
              end else if (r_state == ST_PTR) begin
                w_ptr_nxt   = w_byte[AW-1:0];
                w_state_nxt = ST_PTR_ACK;
              end else begin
                // WHOAMI writes still strobe so the host sees the transfer
                w_reg_we        = (r_ptr != WHOAMI_IDX);
                w_wr_strobe_nxt = 1'b1;
                w_wr_addr_nxt   = r_ptr;
                w_wr_data_nxt   = w_byte;
                w_ptr_nxt       = r_ptr + AW'(1);
                w_state_nxt     = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_slot) begin
              w_sda_oe_nxt = 1'b1;
              w_slot_nxt   = 1'b1;
            end else begin
              w_slot_nxt    = 1'b0;
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = '0;
              if (r_state == ST_ADDR_ACK && r_rw) begin
                w_state_nxt  = ST_RDATA;
                w_shift_nxt  = w_rd_byte;
                w_sda_oe_nxt = ~w_rd_byte[7];
              end else if (r_state == ST_ADDR_ACK) begin
                w_state_nxt = ST_PTR;
              end else begin
                w_state_nxt = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            if (w_last_bit) begin
              w_state_nxt = ST_RDATA_ACK;
              w_ptr_nxt   = r_ptr + AW'(1);
              w_slot_nxt  = 1'b0;
            end
          end else if (w_scl_fall) begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_sda_oe_nxt = ~r_shift[6];
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise && r_slot) begin
            w_mack_nxt = w_sda_lvl;
          end else if (w_scl_fall) begin
            if (!r_slot) begin
              w_sda_oe_nxt = 1'b0;
              w_slot_nxt   = 1'b1;
            end else begin
              w_slot_nxt    = 1'b0;
              w_bit_cnt_nxt = '0;
              if (!r_mack) begin
                w_state_nxt  = ST_RDATA;
                w_shift_nxt  = w_rd_byte;
                w_sda_oe_nxt = ~w_rd_byte[7];
              end else begin
                w_state_nxt  = ST_WAIT_STOP;
                w_sda_oe_nxt = 1'b0;
              end
            end
          end
        end
        default: begin
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_slot      <= 1'b0;
      r_rw        <= 1'b0;
      r_mack      <= 1'b1;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_slot      <= w_slot_nxt;
      r_rw        <= w_rw_nxt;
      r_mack      <= w_mack_nxt;
      r_wr_strobe <= w_wr_strobe_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= 8'h00;
    end else if (w_reg_we) begin
      r_regs[r_ptr] <= w_byte;
    end
  end

  assign o_sda_oe    = r_sda_oe;
  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_busy      = r_busy;

endmodule
